// File: rtl/hwregs_responder.sv
// Memory-mapped LED/7-seg/timer/scratch registers with an optional UART TX FIFO + serializer.
// The UART path exists only when HWREGS_UART_EN is defined; otherwise UART_TX reads 0 and uart_tx idles high.
module hwregs_responder #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        hwregs_request,
    input  logic        hwregs_write,
    input  logic [15:0] hwregs_addr,
    input  logic [3:0]  hwregs_wmask,
    input  logic [31:0] hwregs_wdata,
    input  logic [8:0]  hwregs_tag,
    output logic        hwregs_rvalid,
    output logic [8:0]  hwregs_rtag,
    output logic [31:0] hwregs_rdata,
    output logic [9:0]  led,
    output logic [23:0] seven_seg,
    output logic        uart_tx
);

    localparam logic [13:0] W_LED     = 14'h0000;
    localparam logic [13:0] W_SEG     = 14'h0001;
    localparam logic [13:0] W_UART    = 14'h0004;
    localparam logic [13:0] W_TIMER   = 14'h0008;
    localparam logic [13:0] W_SCRATCH = 14'h0009;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  m
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    logic [13:0] word;
    logic        wr_en;
    logic        rd_en;

    logic [9:0]  led_q, led_d;
    logic [23:0] seg_q, seg_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] scratch_q, scratch_d;
    logic        rvalid_q, rvalid_d;
    logic [8:0]  rtag_q, rtag_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_val;
    logic [31:0] uart_rd;

    assign word  = hwregs_addr[15:2];
    assign wr_en = hwregs_request & hwregs_write;
    assign rd_en = hwregs_request & ~hwregs_write;

    always_comb begin
        led_d     = led_q;
        seg_d     = seg_q;
        scratch_d = scratch_q;
        timer_d   = timer_q + 32'd1;
        if (wr_en) begin
            case (word)
                W_LED:     led_d = 10'(merge({22'b0, led_q}, hwregs_wdata, hwregs_wmask));
                W_SEG:     seg_d = 24'(merge({8'b0, seg_q}, hwregs_wdata, hwregs_wmask));
                W_TIMER:   timer_d = merge(timer_q, hwregs_wdata, hwregs_wmask);
                W_SCRATCH: scratch_d = merge(scratch_q, hwregs_wdata, hwregs_wmask);
                default:   ;
            endcase
        end
    end

    always_comb begin
        case (word)
            W_LED:     rd_val = {22'b0, led_q};
            W_SEG:     rd_val = {8'b0, seg_q};
            W_UART:    rd_val = uart_rd;
            W_TIMER:   rd_val = timer_q;
            W_SCRATCH: rd_val = scratch_q;
            default:   rd_val = '0;
        endcase
    end

    // Response fields are forced to zero outside the single response cycle.
    assign rvalid_d = rd_en;
    assign rtag_d   = rd_en ? hwregs_tag : '0;
    assign rdata_d  = rd_en ? rd_val : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_q     <= '0;
            seg_q     <= '0;
            timer_q   <= '0;
            scratch_q <= '0;
            rvalid_q  <= 1'b0;
            rtag_q    <= '0;
            rdata_q   <= '0;
        end else begin
            led_q     <= led_d;
            seg_q     <= seg_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            rvalid_q  <= rvalid_d;
            rtag_q    <= rtag_d;
            rdata_q   <= rdata_d;
        end
    end

    assign hwregs_rvalid = rvalid_q;
    assign hwregs_rtag   = rtag_q;
    assign hwregs_rdata  = rdata_q;
    assign led           = led_q;
    assign seven_seg     = seg_q;

`ifdef HWREGS_UART_EN
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             push;
    logic             pop;
    logic             last;
    logic             tx;
    logic             busy;
    logic [15:0]      free;
    logic             unused_bits;

    // Full check uses the pre-pop count, so a push into a full FIFO is lost.
    assign push = wr_en && (word == W_UART) && hwregs_wmask[0]
               && (count_q != CNT_W'(FIFO_DEPTH));

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    assign wptr_d  = wptr_q + AW'(push);
    assign rptr_d  = rptr_q + AW'(pop);
    assign last    = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign busy    = (state_q != IDLE) || (count_q != '0);
    assign free    = 16'(FIFO_DEPTH) - 16'(count_q);
    assign uart_rd = {busy, 15'b0, free};
    assign uart_tx = tx;
    assign unused_bits = ^hwregs_addr[1:0];

    always_ff @(posedge clock) begin
        if (push) mem[wptr_q] <= hwregs_wdata[7:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    sh_d    = mem[rptr_q];
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                tx = sh_q[bit_q];
                if (last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (last) begin
                    cnt_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        sh_d    = mem[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end
`else
    logic unused_bits;

    assign uart_rd     = '0;
    assign uart_tx     = 1'b1;
    assign unused_bits = ^{hwregs_addr[1:0], 32'(CLKS_PER_BIT), 32'(FIFO_DEPTH)};
`endif

endmodule

// File: tb/tb_hwregs_responder.sv
// Scoreboard bench for hwregs_responder: random register traffic against a cycle-indexed model,
// plus directed register cases and, with HWREGS_UART_EN, frame decoding of uart_tx.
module tb_hwregs_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic [8:0]  tag = '0;
    logic        rvalid;
    logic [8:0]  rtag;
    logic [31:0] rdata;
    logic [9:0]  led;
    logic [23:0] seven_seg;
    logic        uart_tx;

    hwregs_responder #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .hwregs_request(req), .hwregs_write(wr),
        .hwregs_addr(addr), .hwregs_wmask(wmask),
        .hwregs_wdata(wdata), .hwregs_tag(tag),
        .hwregs_rvalid(rvalid), .hwregs_rtag(rtag),
        .hwregs_rdata(rdata), .led(led),
        .seven_seg(seven_seg), .uart_tx(uart_tx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [8:0]  tag;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    // Reference state; the timer is a base value plus elapsed edges.
    logic [9:0]  led_m = '0;
    logic [23:0] seg_m = '0;
    logic [31:0] scr_m = '0;
    logic [31:0] tbase = '0;
    int          tcyc = 0;

    logic [7:0] rxq[$];
    logic [7:0] sent[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, ex);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: condition not met at cycle %0d", nm, cyc);
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] timer_at(input int k);
        return tbase + 32'(k - tcyc);
    endfunction

    function automatic logic [31:0] rd_model(input logic [15:0] a, input int e);
        case (a[15:2])
            14'h0000: return {22'b0, led_m};
            14'h0001: return {8'b0, seg_m};
            14'h0008: return timer_at(e - 1);
            14'h0009: return scr_m;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic apply_write(input int e, input logic [15:0] a, input logic [3:0] m,
                               input logic [31:0] d);
        logic [31:0] t;
        case (a[15:2])
            14'h0000: begin t = bmerge({22'b0, led_m}, d, m); led_m = t[9:0]; end
            14'h0001: begin t = bmerge({8'b0, seg_m}, d, m); seg_m = t[23:0]; end
            14'h0008: begin tbase = bmerge(timer_at(e - 1), d, m); tcyc = e; end
            14'h0009: scr_m = bmerge(scr_m, d, m);
            default: ;
        endcase
    endtask

    task automatic model_reset();
        led_m = '0; seg_m = '0; scr_m = '0; tbase = '0; tcyc = cyc;
    endtask

    // Issue one request for exactly one cycle; reads push their expectation.
    task automatic issue(input bit w, input logic [15:0] a, input logic [3:0] m,
                         input logic [31:0] d, input logic [8:0] t,
                         input bit fixed, input logic [31:0] fexp);
        exp_t x;
        int   e;
        req = 1'b1; wr = w; addr = a; wmask = m; wdata = d; tag = t;
        e = cyc + 1;
        if (w) apply_write(e, a, m, d);
        else begin
            x.due = e; x.tag = t;
            x.data = fixed ? fexp : rd_model(a, e);
            q.push_back(x);
        end
        @(posedge clock); #1;
        req = 1'b0; wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // Response monitor.
    exp_t mx;
    always @(negedge clock) begin
        if (reset_n) begin
            if (rvalid) begin
                if (q.size() == 0 || q[0].due != cyc) fail("unexpected_rvalid");
                else begin
                    mx = q.pop_front();
                    chk("rtag", {23'b0, rtag}, {23'b0, mx.tag});
                    chk("rdata", rdata, mx.data);
                end
            end else begin
                if (rtag != '0 || rdata != '0) chk("idle_rdata", rdata | {23'b0, rtag}, 32'h0);
                if (q.size() != 0 && q[0].due <= cyc) begin
                    fail("missing_rvalid");
                    void'(q.pop_front());
                end
            end
        end
    end

`ifdef HWREGS_UART_EN
    // Frame decoder: start bit found at its first low cycle, each bit must be 4 uniform cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && uart_tx === 1'b0) begin
                logic [7:0] b;
                logic [3:0] s;
                bit bad;
                bit abrt;
                bad = 0; abrt = 0; b = '0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < 4; j++) begin
                        if (k != 0 || j != 0) @(negedge clock);
                        if (!reset_n) abrt = 1;
                        s[j] = uart_tx;
                    end
                    if (s != 4'h0 && s != 4'hF) bad = 1;
                    if (k == 0 && s != 4'h0) bad = 1;
                    if (k == 9 && s != 4'hF) bad = 1;
                    if (k >= 1 && k <= 8) b[k-1] = s[0];
                end
                if (!abrt) begin
                    checks++;
                    if (bad) begin
                        errors++;
                        $display("FAIL uart_frame_shape: byte 0x%02h malformed", b);
                    end
                    rxq.push_back(b);
                end
            end
        end
    end
`endif

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_led", {22'b0, led}, 32'h0);
        chk("rst_seg", {8'b0, seven_seg}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_rdata", rdata | {23'b0, rtag}, 32'h0);
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        reset_n = 1'b1;
        model_reset();

        // LED write then tagged read
        issue(1, 16'h0000, 4'hF, 32'h0000_03FF, 9'h0, 0, 0);
        issue(0, 16'h0000, 4'h0, 32'h0, 9'h1A5, 1, 32'h0000_03FF);
        idle(1);
        chk("led_out", {22'b0, led}, 32'h3FF);

        // Partial-byte scratch update
        issue(1, 16'h0024, 4'hF, 32'h1122_3344, 9'h0, 0, 0);
        issue(1, 16'h0024, 4'h5, 32'hAABB_CCDD, 9'h0, 0, 0);
        issue(0, 16'h0024, 4'h0, 32'h0, 9'h033, 1, 32'h11BB_33DD);

        // Timer load visibility and wrap
        issue(1, 16'h0020, 4'hF, 32'hFFFF_FFFE, 9'h0, 0, 0);
        issue(0, 16'h0020, 4'h0, 32'h0, 9'h044, 1, 32'hFFFF_FFFE);
        issue(1, 16'h0020, 4'hF, 32'hFFFF_FFFE, 9'h0, 0, 0);
        idle(2);
        issue(0, 16'h0020, 4'h0, 32'h0, 9'h055, 1, 32'h0000_0000);

        // Seven-seg: masked write, upper byte reads zero
        issue(1, 16'h0004, 4'hF, 32'hFFFF_FFFF, 9'h0, 0, 0);
        issue(0, 16'h0004, 4'h0, 32'h0, 9'h066, 1, 32'h00FF_FFFF);
        issue(1, 16'h0007, 4'h2, 32'h0000_0000, 9'h0, 0, 0);
        issue(0, 16'h0006, 4'h0, 32'h0, 9'h077, 1, 32'h00FF_00FF);

        // Unmapped addresses
        issue(1, 16'h0008, 4'hF, 32'hDEAD_BEEF, 9'h0, 0, 0);
        issue(0, 16'h0008, 4'h0, 32'h0, 9'h088, 1, 32'h0);
        issue(0, 16'h1024, 4'h0, 32'h0, 9'h099, 1, 32'h0);

`ifndef HWREGS_UART_EN
        issue(1, 16'h0010, 4'hF, 32'h0000_0041, 9'h0, 0, 0);
        issue(0, 16'h0010, 4'h0, 32'h0, 9'h0AA, 1, 32'h0);
        idle(20);
        chk("uart_tied_high", {31'b0, uart_tx}, 32'h1);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            logic [31:0] r;
            r = $urandom;
            case (r[2:0])
                3'd0: a = 16'h0000;
                3'd1: a = 16'h0004;
                3'd2: a = 16'h0020;
                3'd3: a = 16'h0024;
                3'd4: a = 16'h0010;
                3'd5: a = 16'h0008;
                3'd6: a = 16'($urandom);
                default: a = 16'h0024 | 16'($urandom_range(0, 3));
            endcase
`ifdef HWREGS_UART_EN
            if (a[15:2] == 14'h0004) a = 16'h0100;
`endif
            if (r[4:3] == 2'b00) idle(1);
            else issue(r[5], a, 4'($urandom), $urandom, 9'($urandom), 0, 0);
        end
        idle(1);
        chk("rand_led_out", {22'b0, led}, {22'b0, led_m});
        chk("rand_seg_out", {8'b0, seven_seg}, {8'b0, seg_m});

`ifdef HWREGS_UART_EN
        begin
            int t;
            // Single frame of 0xA5
            rxq.delete();
            issue(1, 16'h0010, 4'h1, 32'h0000_00A5, 9'h0, 0, 0);
            issue(0, 16'h0010, 4'h0, 32'h0, 9'h101, 1, 32'h8000_000F);
            t = 0;
            while (rxq.size() < 1 && t < 200) begin idle(1); t++; end
            if (rxq.size() != 1) fail("uart_frame_timeout");
            else chk("uart_byte_a5", {24'b0, rxq[0]}, 32'hA5);
            issue(0, 16'h0010, 4'h0, 32'h0, 9'h102, 1, 32'h0000_0010);

            // Push without byte-0 enable is ignored
            issue(1, 16'h0010, 4'hE, 32'h0000_0077, 9'h0, 0, 0);
            issue(0, 16'h0010, 4'h0, 32'h0, 9'h103, 1, 32'h0000_0010);

            // 17 back-to-back pushes, 18th dropped
            rxq.delete();
            sent.delete();
            for (int i = 0; i < 17; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                sent.push_back(b);
                issue(1, 16'h0010, 4'h1, {24'b0, b}, 9'h0, 0, 0);
            end
            issue(1, 16'h0010, 4'h1, 32'h0000_00EE, 9'h0, 0, 0);
            issue(0, 16'h0010, 4'h0, 32'h0, 9'h104, 1, 32'h8000_0000);
            t = 0;
            while (rxq.size() < 17 && t < 1200) begin idle(1); t++; end
            if (rxq.size() < 17) fail("uart_burst_timeout");
            else for (int i = 0; i < 17; i++) chk("uart_burst_byte", {24'b0, rxq[i]}, {24'b0, sent[i]});
            idle(60);
            chk("uart_burst_count", rxq.size(), 17);
            issue(0, 16'h0010, 4'h0, 32'h0, 9'h105, 1, 32'h0000_0010);

            // Reset during DATA
            issue(1, 16'h0000, 4'hF, 32'h0000_0155, 9'h0, 0, 0);
            rxq.delete();
            for (int i = 0; i < 3; i++) issue(1, 16'h0010, 4'h1, 32'h0, 9'h0, 0, 0);
            idle(6);
            chk("pre_reset_tx_low", {31'b0, uart_tx}, 32'h0);
            #2 reset_n = 1'b0;
            #1 chk("reset_tx_high", {31'b0, uart_tx}, 32'h1);
            chk("reset_led", {22'b0, led}, 32'h0);
            idle(2);
            reset_n = 1'b1;
            model_reset();
            issue(0, 16'h0010, 4'h0, 32'h0, 9'h106, 1, 32'h0000_0010);
            issue(0, 16'h0000, 4'h0, 32'h0, 9'h107, 1, 32'h0);
            idle(60);
            chk("reset_no_frames", rxq.size(), 0);
        end
`endif

        idle(3);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwregs_responder.md
HWREGS_RESPONDER -- requirements
Module: hwregs_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, UART bit period in clock cycles (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, UART TX FIFO entries, power of two.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port hwregs_request  input  1  single-cycle request strobe.
REQ-006 SHALL have port hwregs_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port hwregs_addr  input  16  byte address; bits [1:0] ignored.
REQ-008 SHALL have port hwregs_wmask  input  4  byte enables for writes.
REQ-009 SHALL have port hwregs_wdata  input  32  write data.
REQ-010 SHALL have port hwregs_tag  input  9  request tag, echoed on response.
REQ-011 SHALL have port hwregs_rvalid  output  1  read response strobe.
REQ-012 SHALL have port hwregs_rtag  output  9  echoed tag.
REQ-013 SHALL have port hwregs_rdata  output  32  read data.
REQ-014 SHALL have port led  output  10  LED register value.
REQ-015 SHALL have port seven_seg  output  24  seven-segment register value.
REQ-016 SHALL have port uart_tx  output  1  serial out, idle high.

Function
REQ-017 Register map SHALL be: 0x0000 LED (RW, bits[9:0]); 0x0004 SEVEN_SEG (RW, bits[23:0]); 0x0010 UART_TX (W: push wdata[7:0]; R: free FIFO slots in [15:0], busy in bit 31); 0x0020 TIMER (RW); 0x0024 SCRATCH (RW, 32 bits).
REQ-018 Read SHALL assert hwregs_rvalid exactly one cycle after the request cycle, with hwregs_rtag = hwregs_tag and hwregs_rdata = register value sampled in the request cycle.
REQ-019 Writes SHALL produce no response; rvalid, rtag and rdata SHALL be 0 in all non-response cycles.
REQ-020 RW registers SHALL update only bytes whose wmask bit is set; unimplemented bits SHALL read 0.
REQ-021 Reads of unmapped addresses SHALL return 0 with a normal response; writes to them SHALL be ignored.
REQ-022 UART_TX push SHALL require wmask[0]=1; a push when the FIFO is full (count evaluated before any same-cycle pop) SHALL be dropped.
REQ-023 TIMER SHALL increment by 1 every cycle and wrap 0xFFFFFFFF -> 0; a write SHALL load masked wdata (unmasked bytes keep the current count) and the loaded value SHALL be visible the next cycle, counting resuming after.
REQ-024 Serializer FSM SHALL have states IDLE, START, DATA, STOP; IDLE -> START when FIFO non-empty (pop in that cycle); START drives 0 for CLKS_PER_BIT cycles; DATA drives bits 0..7 LSB first, CLKS_PER_BIT each; STOP drives 1 for CLKS_PER_BIT cycles, then -> START if FIFO non-empty else IDLE.
REQ-025 busy (UART_TX bit 31) SHALL be 1 whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-026 Simultaneous push and pop on a non-full FIFO SHALL both take effect; count unchanged.

Reset
REQ-027 On reset_n low, SHALL asynchronously clear led, seven_seg, SCRATCH, TIMER, FIFO pointers/count, rvalid, rtag, rdata; FSM -> IDLE; uart_tx = 1.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with queued bytes discarded.

Configuration
REQ-029 With macro HWREGS_UART_EN defined, FIFO and serializer SHALL be built per REQ-022..026.
REQ-030 Without HWREGS_UART_EN, UART_TX SHALL read 0, its writes SHALL be ignored, uart_tx SHALL be tied 1, and no FIFO/FSM logic SHALL exist.

Verification
REQ-031 Write LED 0x3FF mask 0xF, read 0x0000 tag 0x1A5 -> rvalid next cycle, rdata 0x000003FF, rtag 0x1A5.
REQ-032 SCRATCH = 0x11223344, write 0xAABBCCDD mask 0x5 -> reads 0x11BB33DD.
REQ-033 Write TIMER 0xFFFFFFFE, read 2 cycles later -> 0x00000000 (wrap) at the exact cycle.
REQ-034 CLKS_PER_BIT=4, push 0xA5 -> uart_tx: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, 1 for 4 cycles; busy drops afterwards.
REQ-035 17 pushes back-to-back, FIFO_DEPTH=16, serializer started by first push -> 17 frames transmitted; an 18th push while full -> dropped, free count 0.
REQ-036 Pulse reset_n low in DATA state -> uart_tx 1 immediately, free count 16, LED 0.
